inst_encoder: RTL

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder_pkg.sv | 42 ++++
 rtl/inst_encoder_imm_pack.sv | 58 +++++
 rtl/inst_encoder.sv | 104 ++++++++++
 3 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the instruction encoder: format/error codes,
// the NOP word, opcode constants and the queue entry payload.
package inst_encoder_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned QDEPTH = 2;
  localparam int unsigned STAT_W = 16;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_RANGE    = 2'b01,
    ERR_MISALIGN = 2'b10,
    ERR_FMT      = 2'b11
  } err_e;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic            err;
    err_e            code;
  } entry_t;

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// Combinational field packing and immediate legality check for one request.
module imm_pack
  import inst_encoder_pkg::*;
(
  input  logic [2:0]      fmt,
  input  logic [6:0]      opcode,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] imm,
  output entry_t          entry_c
);

  logic [XLEN-1:0] raw;
  err_e            code;

  // A field fits when all bits above its sign bit copy that sign bit.
  always_comb begin
    raw  = '0;
    code = ERR_OK;
    case (fmt_e'(fmt))
      FMT_R: raw = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        raw = {imm[11:0], rs1, funct3, rd, opcode};
        if (!((&imm[31:11]) || !(|imm[31:11]))) code = ERR_RANGE;
      end
      FMT_S: begin
        raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (!((&imm[31:11]) || !(|imm[31:11]))) code = ERR_RANGE;
      end
      FMT_B: begin
        raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        if (imm[0])                                   code = ERR_MISALIGN;
        else if (!((&imm[31:12]) || !(|imm[31:12]))) code = ERR_RANGE;
      end
      FMT_U: begin
        raw = {imm[31:12], rd, opcode};
        if (|imm[11:0]) code = ERR_RANGE;
      end
      FMT_J: begin
        raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (imm[0])                                   code = ERR_MISALIGN;
        else if (!((&imm[31:20]) || !(|imm[31:20]))) code = ERR_RANGE;
      end
      default: code = ERR_FMT;
    endcase
  end

  always_comb begin
    entry_c      = '0;
    entry_c.code = code;
    entry_c.err  = (code != ERR_OK);
    entry_c.inst = entry_c.err ? NOP_INST : raw;
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: accepts field sets, queues encoded words in a
// 2-entry in-order queue with registered outputs, and keeps statistics.
module inst_encoder
  import inst_encoder_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        fmt_i,
  input  logic [6:0]        opcode_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [XLEN-1:0]   imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   inst_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [STAT_W-1:0] enc_count_o,
  output logic [STAT_W-1:0] err_count_o
);

  localparam int unsigned OCC_W = 2;

  entry_t            new_entry_c;
  entry_t            mem_q [QDEPTH];
  entry_t            head_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              accept_c, consume_c, valid_d;

  imm_pack u_imm_pack (
    .fmt     (fmt_i),
    .opcode  (opcode_i),
    .rd      (rd_i),
    .rs1     (rs1_i),
    .rs2     (rs2_i),
    .funct3  (funct3_i),
    .funct7  (funct7_i),
    .imm     (imm_i),
    .entry_c (new_entry_c)
  );

  assign accept_c  = in_valid_i & in_ready_o;
  assign consume_c = out_valid_o & out_ready_i;

  // Next head: a fresh accept lands at the head when it writes the slot the
  // read pointer moves to (empty queue, or accept+consume at occupancy 1).
  always_comb begin
    occ_d    = occ_q + OCC_W'(accept_c) - OCC_W'(consume_c);
    rd_ptr_d = rd_ptr_q ^ consume_c;
    wr_ptr_d = wr_ptr_q ^ accept_c;
    valid_d  = (occ_d != '0);
    head_d   = mem_q[rd_ptr_d];
    if (accept_c && (rd_ptr_d == wr_ptr_q)) head_d = new_entry_c;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (accept_c) mem_q[wr_ptr_q] <= new_entry_c;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Registered view of the next head; payload forced to zero when empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
      inst_o      <= '0;
      err_o       <= 1'b0;
      err_code_o  <= '0;
    end else begin
      out_valid_o <= valid_d;
      in_ready_o  <= (occ_d < OCC_W'(QDEPTH));
      inst_o      <= valid_d ? head_d.inst : '0;
      err_o       <= valid_d ? head_d.err  : 1'b0;
      err_code_o  <= valid_d ? head_d.code : ERR_OK;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enc_count_o <= '0;
      err_count_o <= '0;
    end else if (consume_c) begin
      if (enc_count_o != '1)          enc_count_o <= enc_count_o + STAT_W'(1);
      if (err_o && err_count_o != '1) err_count_o <= err_count_o + STAT_W'(1);
    end
  end

endmodule
